// File: rtl/cos_sched_pkg.sv
// Shared constants, state encoding and helpers for the cosine-accelerator job scheduler.
package cos_sched_pkg;

    localparam int DW_DEF      = 16;
    localparam int FRAC_BITS   = 8;
    localparam int TIMEOUT_DEF = 1023;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_ISSUE     = ST_ISSUE,
        S_WAIT_BUSY = ST_WAIT_BUSY,
        S_WAIT_DONE = ST_WAIT_DONE,
        S_RESP      = ST_RESP
    } sched_state_t;

    // Watchdog must be able to hold the value TIMEOUT itself.
    function automatic int wd_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int WDW_DEF = wd_width(TIMEOUT_DEF);

endpackage

// File: rtl/cos_job_scheduler_if.sv
// Requester-side bus of the cosine job scheduler: job submission and result return.
interface cos_job_scheduler_if
    import cos_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = DW_DEF
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_x;
    logic [NREQ*DW-1:0] req_y;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    resp_valid;
    logic [DW-1:0]      resp_w;
    logic               resp_err;

    modport master (
        output req_valid, req_x, req_y,
        input  req_ready, resp_valid, resp_w, resp_err
    );

    modport slave (
        input  req_valid, req_x, req_y,
        output req_ready, resp_valid, resp_w, resp_err
    );

endinterface

// File: rtl/cos_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    en,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int PW = $clog2(NREQ);

    int idx;

    // Scan from the farthest candidate back to ptr so the closest one wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = 0;
        if (en) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = int'(ptr) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (req[PW'(idx)]) begin
                    gnt             = '0;
                    gnt[PW'(idx)]   = 1'b1;
                    gnt_idx         = PW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/cos_job_scheduler.sv
// Shares one cosine accelerator among NREQ requesters: round-robin grant,
// operand latch, start pulse, watchdog-guarded completion and result return.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | accelerator free; grant a requester when acc_ready=1
//  ISSUE     | one-cycle acc_start, watchdog cleared
//  WAIT_BUSY | waiting for the accelerator to drop Ready
//  WAIT_DONE | waiting for Ready to return with the result
//  RESP      | one-cycle resp_valid to the granted requester
module cos_job_scheduler
    import cos_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    cos_job_scheduler_if.slave  bus,
    output logic                acc_start,
    output logic [DW-1:0]       acc_x,
    output logic [DW-1:0]       acc_y,
    input  logic                acc_ready,
    input  logic [DW-1:0]       acc_w,
    output logic                busy,
    output logic [15:0]         jobs_done
);

    localparam int PW  = $clog2(NREQ);
    localparam int WDW = wd_width(TIMEOUT);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
    localparam logic [PW-1:0]  LAST_REQ = PW'(NREQ - 1);

    sched_state_t    state, state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gnt_idx_q;
    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic            arb_en;
    logic            grant;
    logic [WDW-1:0]  wd_cnt;
    logic [DW-1:0]   acc_x_q, acc_y_q;
    logic [DW-1:0]   resp_w_q;
    logic            resp_err_q;
    logic [15:0]     jobs_q;
    logic            done_ok, done_err;

    // Gating with rst keeps req_ready low while reset is held.
    assign arb_en = (state == S_IDLE) && acc_ready && !rst;
    assign grant  = |arb_gnt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .en      (arb_en),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A Ready return in the timeout cycle takes precedence over the abort.
    always_comb begin
        state_nxt = state;
        done_ok   = 1'b0;
        done_err  = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (wd_cnt == WD_LIMIT) begin
                    done_err  = 1'b1;
                    state_nxt = S_RESP;
                end else if (!acc_ready) begin
                    state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (acc_ready) begin
                    done_ok   = 1'b1;
                    state_nxt = S_RESP;
                end else if (wd_cnt == WD_LIMIT) begin
                    done_err  = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            gnt_idx_q  <= '0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            wd_cnt     <= '0;
            resp_w_q   <= '0;
            resp_err_q <= 1'b0;
            jobs_q     <= '0;
        end else begin
            if (grant) begin
                gnt_idx_q <= arb_idx;
                rr_ptr    <= (arb_idx == LAST_REQ) ? '0 : arb_idx + 1'b1;
                acc_x_q   <= bus.req_x[arb_idx*DW +: DW];
                acc_y_q   <= bus.req_y[arb_idx*DW +: DW];
            end
            if (state == S_ISSUE) begin
                wd_cnt <= '0;
            end else if (state == S_WAIT_BUSY || state == S_WAIT_DONE) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (done_ok) begin
                resp_w_q   <= acc_w;
                resp_err_q <= 1'b0;
            end else if (done_err) begin
                resp_w_q   <= '0;
                resp_err_q <= 1'b1;
            end
            if (state == S_RESP && !resp_err_q) begin
                jobs_q <= jobs_q + 16'd1;
            end
        end
    end

    assign bus.req_ready  = arb_gnt;
    assign bus.resp_valid = (state == S_RESP) ? (NREQ'(1) << gnt_idx_q) : '0;
    assign bus.resp_w     = resp_w_q;
    assign bus.resp_err   = resp_err_q;
    assign acc_start      = (state == S_ISSUE);
    assign acc_x          = acc_x_q;
    assign acc_y          = acc_y_q;
    assign busy           = (state != S_IDLE);
    assign jobs_done      = jobs_q;

endmodule
